// File: rtl/coffee_pkg.sv
// Shared types and display codes for the coffee machine brew controller.
package coffee_pkg;

    localparam int unsigned SEG_W = 4;

    localparam logic [SEG_W-1:0] SEG_IDLE  = 4'd0;
    localparam logic [SEG_W-1:0] SEG_FAULT = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRIND = 3'd1,
        BREW  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Phase length in seconds as a display/timer code.
    function automatic logic [SEG_W-1:0] secs(input int unsigned s);
        return SEG_W'(s);
    endfunction

endpackage

// File: rtl/brew_sequencer_sec_tick.sv
// One-second prescaler: tick_c is high for one cycle every TICK_DIV cycles.
module sec_tick #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(TICK_DIV - 1));

    // Clear restarts the second so a freshly entered phase gets a full one.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/brew_sequencer.sv
// Coffee machine cycle controller: GRIND -> BREW -> DONE with countdown display.
module brew_sequencer
    import coffee_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50_000_000,
    parameter int unsigned GRIND_S      = 3,
    parameter int unsigned BREW_SMALL_S = 5,
    parameter int unsigned BREW_LARGE_S = 9,
    parameter int unsigned DONE_S       = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Cancel,
    input  logic             Cup_sel,
    input  logic             Water_ok,
    output logic [SEG_W-1:0] Seg,
    output logic             Grinder,
    output logic             Pump,
    output logic             Ready,
    output logic             Busy
);

    localparam int unsigned TIMER_W = SEG_W;

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic               cup_large, cup_large_next;
    logic               tick_c;
    logic               tick_clr_c;

    logic [SEG_W-1:0]   seg_next;
    logic               grinder_next, pump_next, ready_next, busy_next;

    assign tick_clr_c = (state_next != state);

    sec_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_sec_tick (
        .clk    (Clk),
        .rst    (Rst),
        .clr    (tick_clr_c),
        .tick_c (tick_c)
    );

    // State, timer and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            timer     <= '0;
            cup_large <= 1'b0;
            Seg       <= SEG_IDLE;
            Grinder   <= 1'b0;
            Pump      <= 1'b0;
            Ready     <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            cup_large <= cup_large_next;
            Seg       <= seg_next;
            Grinder   <= grinder_next;
            Pump      <= pump_next;
            Ready     <= ready_next;
            Busy      <= busy_next;
        end
    end

    // Next state: Cancel > water fault > tick completion > Start.
    always_comb begin
        state_next     = state;
        timer_next     = timer;
        cup_large_next = cup_large;
        case (state)
            IDLE: begin
                if (!Cancel && Start) begin
                    if (Water_ok) begin
                        state_next     = GRIND;
                        timer_next     = secs(GRIND_S);
                        cup_large_next = Cup_sel;
                    end else begin
                        state_next = FAULT;
                    end
                end
            end
            GRIND, BREW: begin
                if (Cancel) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (!Water_ok) begin
                    state_next = FAULT;
                end else if (tick_c) begin
                    if (timer == TIMER_W'(1)) begin
                        if (state == GRIND) begin
                            state_next = BREW;
                            timer_next = cup_large ? secs(BREW_LARGE_S) : secs(BREW_SMALL_S);
                        end else begin
                            state_next = DONE;
                            timer_next = secs(DONE_S);
                        end
                    end else begin
                        timer_next = timer - TIMER_W'(1);
                    end
                end
            end
            DONE: begin
                if (Cancel) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (tick_c) begin
                    if (timer == TIMER_W'(1)) begin
                        state_next = IDLE;
                        timer_next = '0;
                    end else begin
                        timer_next = timer - TIMER_W'(1);
                    end
                end
            end
            FAULT: begin
                if (Cancel) begin
                    state_next = IDLE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Output decode from the state being entered, so outputs align with it.
    always_comb begin
        seg_next     = SEG_IDLE;
        grinder_next = 1'b0;
        pump_next    = 1'b0;
        ready_next   = 1'b0;
        busy_next    = 1'b0;
        case (state_next)
            GRIND: begin
                seg_next     = timer_next;
                grinder_next = 1'b1;
                busy_next    = 1'b1;
            end
            BREW: begin
                seg_next  = timer_next;
                pump_next = 1'b1;
                busy_next = 1'b1;
            end
            DONE:    ready_next = 1'b1;
            FAULT:   seg_next   = SEG_FAULT;
            default: seg_next   = SEG_IDLE;
        endcase
    end

endmodule
